// File: rtl/dram_request_queue.sv
// dram_request_queue
//
// Front-end for dram_controller. User read/write requests are buffered in a
// small FIFO and handed to the controller one at a time over its u_* command
// port, using the busy/ack handshake. Read data is returned to the requester
// in issue order. A per-read watchdog ends a hung read with an error response.
//
// Ports
//   u_clk, u_rst        single clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready = queue not full)
//   req_cmd             1 = write, 0 = read
//   req_addr            {bank_id, row, col}
//   req_wdata           write data (ignored for reads)
//   rsp_valid           one-cycle pulse when a read completes
//   rsp_data            read data (0 when rsp_err)
//   rsp_err             read timed out
//   q_count             queued entries, excluding the in-flight request
//   ctl_en/addr/wdata/cmd   drive controller u_en/u_addr/u_data_i/u_cmd
//   ctl_cmd_ack, ctl_busy   from controller u_cmd_ack/u_busy
//   ctl_rd_data/rd_valid    from controller u_data_o/u_data_valid

module dram_request_queue #(
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 128,
    parameter int NUMBER_OF_BANKS   = 8,
    parameter int U_DATA_WIDTH      = 2,
    parameter int DRAM_DATA_WIDTH   = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 64,
    localparam int U_ADDR_WIDTH = $clog2(NUMBER_OF_BANKS) + $clog2(NUMBER_OF_ROWS)
                                + $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
    localparam int CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    u_clk,
    input  logic                    u_rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_cmd,
    input  logic [U_ADDR_WIDTH-1:0] req_addr,
    input  logic [U_DATA_WIDTH-1:0] req_wdata,

    output logic                    rsp_valid,
    output logic [U_DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_err,

    output logic [CNT_WIDTH-1:0]    q_count,

    output logic                    ctl_en,
    output logic [U_ADDR_WIDTH-1:0] ctl_addr,
    output logic [U_DATA_WIDTH-1:0] ctl_wdata,
    output logic                    ctl_cmd,
    input  logic                    ctl_cmd_ack,
    input  logic                    ctl_busy,
    input  logic [U_DATA_WIDTH-1:0] ctl_rd_data,
    input  logic                    ctl_rd_valid
);

    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_WIDTH = 1 + U_ADDR_WIDTH + U_DATA_WIDTH;
    localparam int WD_WIDTH    = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [WD_WIDTH-1:0]  WD_LIMIT   = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        WAIT_WR
    } state_t;

    state_t                  state;
    logic [WD_WIDTH-1:0]     wd_cnt;

    logic [ENTRY_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [PTR_WIDTH-1:0]    rd_ptr;
    logic [ENTRY_WIDTH-1:0]  head;
    logic                    push;
    logic                    pop;

    // Full blocks new requests even on a popping cycle: ready depends only
    // on the registered count, never on the pop in progress.
    assign req_ready = (q_count != FULL_COUNT);
    assign push      = req_valid && req_ready;
    // The head stays in the queue while it is being offered to the
    // controller; it only leaves once the command is acknowledged.
    assign pop       = (state == ISSUE) && ctl_cmd_ack;
    assign head      = fifo_mem[rd_ptr];

    // Queue storage: payload only, no reset needed.
    always_ff @(posedge u_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_cmd, req_addr, req_wdata};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_WIDTH'(1);
                2'b01:   q_count <= q_count - CNT_WIDTH'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Issue FSM with registered controller and response outputs.
    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            ctl_en    <= 1'b0;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
            ctl_cmd   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // Response is a single-cycle pulse; clear it unless set below.
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if ((q_count != '0) && !ctl_busy) begin
                        {ctl_cmd, ctl_addr, ctl_wdata} <= head;
                        ctl_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    // ctl_* hold their values until the controller acks.
                    if (ctl_cmd_ack) begin
                        ctl_en <= 1'b0;
                        wd_cnt <= '0;
                        state  <= ctl_cmd ? WAIT_WR : WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    // Real data wins over a timeout landing on the same edge.
                    if (ctl_rd_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ctl_rd_data;
                        state     <= IDLE;
                    end else if (wd_cnt == WD_LIMIT) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_WIDTH'(1);
                    end
                end

                WAIT_WR: begin
                    if (!ctl_busy) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
